// File: rtl/fetch_queue_if.sv
// Bundle of the fetch unit's memory-read, redirect/halt and decode-stream signals.
// Decode stream: the head entry transfers on a rising clk edge when out_valid && out_ready (and no redirect).
interface fetch_queue_if #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 4
);
  logic                     imem_req;
  logic [ADDR_W-1:0]        imem_addr;
  logic [INSTR_W-1:0]       imem_rdata;
  logic                     halt;
  logic                     redirect;
  logic [ADDR_W-1:0]        redirect_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [INSTR_W-1:0]       out_instr;
  logic [ADDR_W-1:0]        out_npc;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_npc, level,
    input  imem_rdata, halt, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_npc, level,
    output imem_rdata, halt, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch with a DEPTH-entry prefetch queue of {next-PC, instruction} pairs,
// one-cycle-latency memory reads, branch redirect flush and halt.
module fetch_queue #(
  parameter int INSTR_W  = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_npc_q, inflight_npc_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];
  logic [ADDR_W-1:0]  npc_mem_q [DEPTH];
  logic [ADDR_W-1:0]  npc_mem_d [DEPTH];

  logic               pop;
  logic               req;
  logic               wr_en;
  logic [CW1-1:0]     credit;

  always_comb begin
    pop    = (count_q != '0) & bus.out_ready & ~bus.redirect;
    // Occupancy the queue will need once the outstanding read lands, net of this cycle's pop.
    credit = {1'b0, count_q} + CW1'(inflight_q) - CW1'(pop);
    req    = ~rst & ~bus.halt & ~bus.redirect & (credit < CW1'(DEPTH));
    wr_en  = inflight_q & ~bus.redirect;
  end

  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    inflight_d     = inflight_q;
    inflight_npc_d = inflight_npc_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    instr_mem_d    = instr_mem_q;
    npc_mem_d      = npc_mem_q;

    if (bus.redirect) begin
      // The response arriving now belongs to the abandoned path and is dropped.
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = 1'b0;
      fetch_pc_d = bus.redirect_pc;
    end else begin
      if (wr_en) begin
        instr_mem_d[wr_ptr_q] = bus.imem_rdata;
        npc_mem_d[wr_ptr_q]   = inflight_npc_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(wr_en) - CW'(pop);
      if (req) begin
        inflight_d     = 1'b1;
        inflight_npc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        fetch_pc_d     = fetch_pc_q + ADDR_W'(PC_STEP);
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q     <= ADDR_W'(RESET_PC);
      inflight_q     <= 1'b0;
      inflight_npc_q <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        npc_mem_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      inflight_q     <= inflight_d;
      inflight_npc_q <= inflight_npc_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      instr_mem_q    <= instr_mem_d;
      npc_mem_q      <= npc_mem_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = instr_mem_q[rd_ptr_q];
  assign bus.out_npc   = npc_mem_q[rd_ptr_q];
  assign bus.level     = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_fetch_queue;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam int DEPTH   = 4;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;
  int n_req    = 0;
  logic [15:0] last_req_addr;

  // Reference model state
  logic [31:0] exp_q[$];       // {npc, instr}, head at index 0
  logic [15:0] m_fetch_pc;
  logic        m_pend;
  logic [15:0] m_pend_addr;

  fetch_queue_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PC_STEP(2), .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] imem_word(input logic [15:0] addr);
    return addr ^ 16'hC3A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_fetch_pc  = 16'h0000;
    m_pend      = 1'b0;
    m_pend_addr = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_req"},   {31'd0, bus.imem_req},  32'd0);
    check({tag, "_level"}, 32'(bus.level),         32'd0);
    check({tag, "_instr"}, 32'(bus.out_instr),     32'd0);
    check({tag, "_npc"},   32'(bus.out_npc),       32'd0);
  endtask

  // Called in the negedge phase; returns in the next negedge phase.
  task automatic cycle(input logic h, input logic r, input logic [15:0] rpc, input logic rdy);
    logic e_valid, e_pop, e_req;
    bus.halt        = h;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.out_ready   = rdy;
    bus.imem_rdata  = m_pend ? imem_word(m_pend_addr) : 16'($urandom);
    #1;
    e_valid = (exp_q.size() != 0);
    e_pop   = e_valid & rdy & ~r;
    e_req   = ~h & ~r & ((exp_q.size() + int'(m_pend) - int'(e_pop)) < DEPTH);
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, e_valid});
    check("level", 32'(bus.level), 32'(exp_q.size()));
    if (e_valid) begin
      check("out_instr", 32'(bus.out_instr), 32'(exp_q[0][15:0]));
      check("out_npc",   32'(bus.out_npc),   32'(exp_q[0][31:16]));
    end
    check("imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
    if (e_req) check("imem_addr", 32'(bus.imem_addr), 32'(m_fetch_pc));
    if (bus.imem_req) begin
      n_req++;
      last_req_addr = bus.imem_addr;
    end
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_pend     = 1'b0;
      m_fetch_pc = rpc;
    end else begin
      if (e_pop) void'(exp_q.pop_front());
      if (m_pend) exp_q.push_back({m_pend_addr + 16'd2, imem_word(m_pend_addr)});
      if (e_req) begin
        m_pend      = 1'b1;
        m_pend_addr = m_fetch_pc;
        m_fetch_pc  = m_fetch_pc + 16'd2;
      end else begin
        m_pend = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.halt = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
    bus.imem_rdata = 16'($urandom);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus.halt = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
    bus.imem_rdata = '0;
    model_reset();

    // Stream with decode always ready
    do_reset();
    check("first_addr", 32'(bus.imem_addr), 32'h0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);

    // Backpressure from reset: fills to DEPTH, then one ready cycle frees one credit
    do_reset();
    n_req = 0;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("bp_req_count", 32'(n_req), 32'd4);
    check("bp_level_full", 32'(bus.level), 32'd4);
    n_req = 0;
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("bp_reissue_addr", 32'(last_req_addr), 32'h8);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("bp_one_req", 32'(n_req), 32'd1);

    // Redirect with level 2 and a read outstanding
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("rd_level_before", 32'(bus.level), 32'd2);
    cycle(1'b0, 1'b1, 16'h0100, 1'b0);
    check("rd_level_after", 32'(bus.level), 32'd0);
    check("rd_addr_after", 32'(bus.imem_addr), 32'h0100);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);

    // Halt for 5 cycles mid-stream
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);
    n_req = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check("halt_no_req", 32'(n_req), 32'd0);
    check("halt_drained", 32'(bus.level), 32'd0);
    check("halt_resume_addr", 32'(bus.imem_addr), 32'(m_fetch_pc));
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);

    // Address wrap and pointer wrap
    do_reset();
    cycle(1'b0, 1'b1, 16'hFFFC, 1'b1);
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 16'h0, (i % 5) != 3);

    // Asynchronous reset between edges with level 3
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("ar_level_before", 32'(bus.level), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("ar_first_addr", 32'(bus.imem_addr), 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 7) == 0,
            $urandom_range(0, 24) == 0,
            {16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE},
            $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
